// File: rtl/fifo_rr_drain_arb.sv
// Round-robin drain arbiter for N show-ahead FIFOs feeding one registered
// valid/ready output stage. A grant can be held for up to BURST words.
module fifo_rr_drain_arb #(
  parameter int N     = 4,
  parameter int WIDTH = 31,
  parameter int BURST = 4,
  parameter int SRC_W = $clog2(N)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [N-1:0]       in_empty,
  input  logic [N*WIDTH-1:0] in_data,
  output logic [N-1:0]       in_rd_en,
  input  logic [N-1:0]       req_mask,
  output logic               out_valid,
  output logic [WIDTH-1:0]   out_data,
  output logic [SRC_W-1:0]   out_src,
  input  logic               out_ready,
  output logic               busy
);
  localparam int                 CNT_W     = $clog2(BURST + 1);
  localparam logic [CNT_W-1:0]   BURST_MAX = CNT_W'(BURST);
  localparam logic [SRC_W-1:0]   LAST_IDX  = SRC_W'(N - 1);
  localparam logic [SRC_W:0]     N_EXT     = (SRC_W + 1)'(N);
  localparam logic [N-1:0]       ONE_HOT   = N'(1);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    LOCK = 1'b1
  } state_t;

  state_t             state_r;
  logic [SRC_W-1:0]   rr_ptr_r;
  logic [SRC_W-1:0]   owner_r;
  logic [CNT_W-1:0]   burst_cnt_r;

  logic [N-1:0]       eligible_s;
  logic               can_load_s;
  logic               keep_owner_s;
  logic               scan_hit_s;
  logic [SRC_W-1:0]   scan_idx_s;
  logic [SRC_W:0]     sum_s;
  logic [SRC_W-1:0]   cand_s;
  logic [SRC_W-1:0]   grant_s;
  logic               grant_valid_s;
  logic               pop_s;
  logic               continued_s;
  logic [WIDTH-1:0]   head_s;

  // Grant selection: keep a live burst owner, otherwise first eligible FIFO from rr_ptr
  always_comb begin
    eligible_s   = req_mask & ~in_empty;
    can_load_s   = ~out_valid | out_ready;
    keep_owner_s = (state_r == LOCK) && eligible_s[owner_r] && (burst_cnt_r < BURST_MAX);
    scan_hit_s   = 1'b0;
    scan_idx_s   = {SRC_W{1'b0}};
    sum_s        = {(SRC_W + 1){1'b0}};
    cand_s       = {SRC_W{1'b0}};
    // Scan from the far end so the candidate nearest rr_ptr is written last and wins
    for (int k = N - 1; k >= 0; k--) begin
      sum_s      = {1'b0, rr_ptr_r} + (SRC_W + 1)'(k);
      cand_s     = (sum_s >= N_EXT) ? SRC_W'(sum_s - N_EXT) : SRC_W'(sum_s);
      scan_hit_s = scan_hit_s | eligible_s[cand_s];
      scan_idx_s = eligible_s[cand_s] ? cand_s : scan_idx_s;
    end
    grant_s       = keep_owner_s ? owner_r : scan_idx_s;
    grant_valid_s = keep_owner_s | scan_hit_s;
    pop_s         = can_load_s & grant_valid_s & ~rst;
    continued_s   = (state_r == LOCK) && (grant_s == owner_r);
    head_s        = in_data[grant_s*WIDTH +: WIDTH];
  end

  assign in_rd_en = pop_s ? (ONE_HOT << grant_s) : {N{1'b0}};
  assign busy     = (state_r == LOCK);

  // Output register, ownership and burst accounting
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r     <= IDLE;
      rr_ptr_r    <= {SRC_W{1'b0}};
      owner_r     <= {SRC_W{1'b0}};
      burst_cnt_r <= {CNT_W{1'b0}};
      out_valid   <= 1'b0;
      out_data    <= {WIDTH{1'b0}};
      out_src     <= {SRC_W{1'b0}};
    end else if (pop_s) begin
      out_valid <= 1'b1;
      out_data  <= head_s;
      out_src   <= grant_s;
      if (continued_s) begin
        burst_cnt_r <= (burst_cnt_r == BURST_MAX) ? burst_cnt_r : burst_cnt_r + CNT_W'(1);
      end else begin
        state_r     <= LOCK;
        owner_r     <= grant_s;
        burst_cnt_r <= CNT_W'(1);
        rr_ptr_r    <= (grant_s == LAST_IDX) ? {SRC_W{1'b0}} : grant_s + SRC_W'(1);
      end
    end else begin
      if (out_ready) begin
        out_valid <= 1'b0;
      end else begin
        out_valid <= out_valid;
      end
      // With room to load but nothing to grant, the burst is over
      if (can_load_s) begin
        state_r <= IDLE;
      end else begin
        state_r <= state_r;
      end
    end
  end

endmodule
